// File: rtl/alu_cmd_driver.sv
// Command FIFO + issue FSM in front of a combinational 32-bit ALU; returns results in order.
// Optional build macro ALU_DRV_CNT_EN adds a 16-bit completed-response counter output op_count.
module alu_cmd_driver #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  input  logic [2:0]       cmd_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_opcode,
  input  logic [WIDTH-1:0] alu_c,
  input  logic [2:0]       alu_d,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_c,
  output logic [2:0]       rsp_d,
  output logic [2:0]       rsp_op,
  output logic             busy
`ifdef ALU_DRV_CNT_EN
  ,
  output logic [15:0]      op_count
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       op;
  } cmd_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  cmd_t             fifo_mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  state_e           state_q, state_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d;
  logic [WIDTH-1:0] alu_b_q, alu_b_d;
  logic [2:0]       alu_op_q, alu_op_d;
  logic [WIDTH-1:0] rsp_c_q, rsp_c_d;
  logic [2:0]       rsp_d_q, rsp_d_d;
  logic [2:0]       rsp_op_q, rsp_op_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             push, pop, rsp_fire;
  cmd_t             head;

  // No bypass: a pop in the same cycle never frees a slot for a push.
  assign cmd_ready = (count_q != CW'(DEPTH)) && !rst;
  assign push      = cmd_valid && cmd_ready;
  assign rsp_fire  = rsp_valid_q && rsp_ready;
  assign head      = fifo_mem_q[rd_ptr_q];

  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    state_d     = state_q;
    pop         = 1'b0;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_op_d    = alu_op_q;
    rsp_c_d     = rsp_c_q;
    rsp_d_d     = rsp_d_q;
    rsp_op_d    = rsp_op_q;
    rsp_valid_d = rsp_valid_q;
    case (state_q)
      ST_IDLE: begin
        if (count_q != '0) begin
          pop      = 1'b1;
          alu_a_d  = head.a;
          alu_b_d  = head.b;
          alu_op_d = head.op;
          rsp_op_d = head.op;
          state_d  = ST_EXEC;
        end
      end
      ST_EXEC: begin
        rsp_c_d     = alu_c;
        rsp_d_d     = alu_d;
        rsp_valid_d = 1'b1;
        state_d     = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_fire) begin
          rsp_valid_d = 1'b0;
          if (count_q != '0) begin
            pop      = 1'b1;
            alu_a_d  = head.a;
            alu_b_d  = head.b;
            alu_op_d = head.op;
            rsp_op_d = head.op;
            state_d  = ST_EXEC;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: the FIFO storage is deliberately not reset; only pointers and count define its contents.
  always_ff @(posedge clk) begin
    if (push) fifo_mem_q[wr_ptr_q] <= {cmd_a, cmd_b, cmd_op};
  end

  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_op_q    <= '0;
      rsp_c_q     <= '0;
      rsp_d_q     <= '0;
      rsp_op_q    <= '0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_op_q    <= alu_op_d;
      rsp_c_q     <= rsp_c_d;
      rsp_d_q     <= rsp_d_d;
      rsp_op_q    <= rsp_op_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_opcode = alu_op_q;
  assign rsp_c      = rsp_c_q;
  assign rsp_d      = rsp_d_q;
  assign rsp_op     = rsp_op_q;
  assign rsp_valid  = rsp_valid_q;
  assign busy       = (state_q != ST_IDLE) || (count_q != '0);

`ifdef ALU_DRV_CNT_EN
  logic [15:0] op_count_q, op_count_d;

  always_comb begin
    op_count_d = op_count_q;
    if (rsp_fire) op_count_d = op_count_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) op_count_q <= '0;
    else     op_count_q <= op_count_d;
  end

  assign op_count = op_count_q;
`endif

endmodule

// File: tb/tb_alu_cmd_driver.sv
// Self-checking bench for alu_cmd_driver: directed scenarios plus randomized traffic
// against an in-order response queue fed by a behavioural ALU model.
module tb_alu_cmd_driver;

  localparam int WIDTH = 32;
  localparam int DEPTH = 4;

  logic        clk;
  logic        rst;
  logic        cmd_valid, cmd_ready;
  logic [31:0] cmd_a, cmd_b;
  logic [2:0]  cmd_op;
  logic [31:0] alu_a, alu_b, alu_c;
  logic [2:0]  alu_opcode, alu_d;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_c;
  logic [2:0]  rsp_d, rsp_op;
  logic        busy;
`ifdef ALU_DRV_CNT_EN
  logic [15:0] op_count;
`endif

  alu_cmd_driver #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_a      (cmd_a),
    .cmd_b      (cmd_b),
    .cmd_op     (cmd_op),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_opcode (alu_opcode),
    .alu_c      (alu_c),
    .alu_d      (alu_d),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_c      (rsp_c),
    .rsp_d      (rsp_d),
    .rsp_op     (rsp_op),
    .busy       (busy)
`ifdef ALU_DRV_CNT_EN
    ,
    .op_count   (op_count)
`endif
  );

  typedef struct {
    logic [31:0] c;
    logic [2:0]  d;
    logic [2:0]  op;
  } rsp_t;

  rsp_t exp_q[$];
  rsp_t prev_rsp;
  logic hold_prev = 1'b0;
  int   checks    = 0;
  int   failures  = 0;
  int   cyc       = 0;
  int   n_acc     = 0;
  int   n_rsp     = 0;
  int   exp_cnt   = 0;

  function automatic logic [31:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                         input logic [2:0] op);
    case (op)
      3'b000:  return a << b[4:0];
      3'b001:  return 32'($signed(a) >>> b[4:0]);
      3'b010:  return a + b;
      3'b011:  return a - b;
      3'b100:  return a * b;
      3'b101:  return a & b;
      3'b110:  return a | b;
      default: return ~a;
    endcase
  endfunction

  function automatic logic [2:0] flag_fn(input logic [31:0] c);
    return {c == 32'd0, c[31], ^c};
  endfunction

  // Combinational ALU stand-in driven by the DUT's registered operands.
  assign alu_c = alu_fn(alu_a, alu_b, alu_opcode);
  assign alu_d = flag_fn(alu_c);

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Evaluates the handshakes of the current cycle against the model, then advances one clock.
  task automatic step();
    rsp_t        e;
    logic [31:0] c;
    #1;
    if (hold_prev) begin
      check("rsp_hold_valid", 32'(rsp_valid), 32'd1);
      check("rsp_hold_c", rsp_c, prev_rsp.c);
      check("rsp_hold_d", 32'(rsp_d), 32'(prev_rsp.d));
      check("rsp_hold_op", 32'(rsp_op), 32'(prev_rsp.op));
    end
    if (rst) begin
      exp_q.delete();
      exp_cnt   = 0;
      hold_prev = 1'b0;
    end else begin
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_rsp", 32'(rsp_valid), 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("rsp_c", rsp_c, e.c);
          check("rsp_d", 32'(rsp_d), 32'(e.d));
          check("rsp_op", 32'(rsp_op), 32'(e.op));
          n_rsp++;
          exp_cnt++;
        end
      end
      if (cmd_valid && cmd_ready) begin
        c = alu_fn(cmd_a, cmd_b, cmd_op);
        exp_q.push_back('{c: c, d: flag_fn(c), op: cmd_op});
        n_acc++;
      end
      hold_prev   = rsp_valid && !rsp_ready;
      prev_rsp.c  = rsp_c;
      prev_rsp.d  = rsp_d;
      prev_rsp.op = rsp_op;
    end
    @(negedge clk);
    #1;
    cyc++;
  endtask

  task automatic wait_rsp(input int max, output int at);
    for (int i = 0; i < max && !rsp_valid; i++) step();
    if (!rsp_valid) check("rsp_timeout", 32'(rsp_valid), 32'd1);
    at = cyc;
  endtask

  initial begin
    int t0, t1, t2, na, nr;
    logic [31:0] b_rand;

    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_a     = '0;
    cmd_b     = '0;
    cmd_op    = '0;
    rsp_ready = 1'b0;

    // Reset held for two clock edges.
    @(negedge clk);
    #1;
    step();
    check("rst_alu_a", alu_a, 32'd0);
    check("rst_alu_b", alu_b, 32'd0);
    check("rst_alu_opcode", 32'(alu_opcode), 32'd0);
    check("rst_rsp_c", rsp_c, 32'd0);
    check("rst_rsp_d", 32'(rsp_d), 32'd0);
    check("rst_rsp_op", 32'(rsp_op), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
`ifdef ALU_DRV_CNT_EN
    check("rst_op_count", 32'(op_count), 32'd0);
`endif
    rst = 1'b0;
    #1;
    check("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("post_rst_busy", 32'(busy), 32'd0);

    // Single NOT: cycle-exact latency.
    b_rand    = $urandom;
    cmd_a     = 32'hFFFF_FFFF;
    cmd_b     = b_rand;
    cmd_op    = 3'b111;
    cmd_valid = 1'b1;
    rsp_ready = 1'b1;
    step();
    cmd_valid = 1'b0;
    check("single_n1_rsp_valid", 32'(rsp_valid), 32'd0);
    step();
    check("single_n2_alu_a", alu_a, 32'hFFFF_FFFF);
    check("single_n2_alu_b", alu_b, b_rand);
    check("single_n2_alu_opcode", 32'(alu_opcode), 32'd7);
    check("single_n2_rsp_valid", 32'(rsp_valid), 32'd0);
    step();
    check("single_n3_rsp_valid", 32'(rsp_valid), 32'd1);
    check("single_n3_rsp_c", rsp_c, 32'h0000_0000);
    check("single_n3_rsp_d", 32'(rsp_d), 32'd4);
    check("single_n3_rsp_op", 32'(rsp_op), 32'd7);
    step();
    check("single_n4_rsp_valid", 32'(rsp_valid), 32'd0);
    check("single_n4_busy", 32'(busy), 32'd0);

    // Ordering: add 5+7 then sub 3-10, back-to-back.
    t0        = cyc;
    cmd_a     = 32'd5;
    cmd_b     = 32'd7;
    cmd_op    = 3'b010;
    cmd_valid = 1'b1;
    step();
    cmd_a  = 32'd3;
    cmd_b  = 32'd10;
    cmd_op = 3'b011;
    check("order_cmd_ready_2nd", 32'(cmd_ready), 32'd1);
    step();
    cmd_valid = 1'b0;
    wait_rsp(10, t1);
    check("order_lat_first", 32'(t1 - t0), 32'd3);
    check("order_rsp_c_add", rsp_c, 32'h0000_000C);
    check("order_rsp_op_add", 32'(rsp_op), 32'd2);
    step();
    wait_rsp(10, t2);
    check("order_gap", 32'(t2 - t1), 32'd2);
    check("order_rsp_c_sub", rsp_c, 32'hFFFF_FFF9);
    check("order_rsp_op_sub", 32'(rsp_op), 32'd3);
    step();
    check("order_busy_after", 32'(busy), 32'd0);
`ifdef ALU_DRV_CNT_EN
    check("op_count_after_3", 32'(op_count), 32'd3);
`endif

    // Back-pressure: six back-to-back commands, five fit.
    rsp_ready = 1'b0;
    na        = n_acc;
    for (int i = 0; i < 6; i++) begin
      cmd_a     = $urandom;
      cmd_b     = $urandom;
      cmd_op    = 3'($urandom_range(0, 7));
      cmd_valid = 1'b1;
      check($sformatf("full_cmd_ready_%0d", i), 32'(cmd_ready), (i < 5) ? 32'd1 : 32'd0);
      step();
    end
    for (int i = 0; i < 3; i++) begin
      check($sformatf("full_hold_cmd_ready_%0d", i), 32'(cmd_ready), 32'd0);
      check($sformatf("full_hold_busy_%0d", i), 32'(busy), 32'd1);
      step();
    end
    check("full_accepted", 32'(n_acc - na), 32'd5);
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    nr        = n_rsp;
    for (int i = 0; i < 30 && (n_rsp - nr) < 5; i++) step();
    check("full_drained", 32'(n_rsp - nr), 32'd5);
    check("full_cmd_ready_after", 32'(cmd_ready), 32'd1);
    check("full_busy_after", 32'(busy), 32'd0);

    // Reset while in RESP with two commands queued.
    rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cmd_a     = $urandom;
      cmd_b     = $urandom;
      cmd_op    = 3'($urandom_range(0, 7));
      cmd_valid = 1'b1;
      step();
    end
    cmd_valid = 1'b0;
    wait_rsp(10, t1);
    check("midrst_busy_before", 32'(busy), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_alu_a", alu_a, 32'd0);
    check("midrst_cmd_ready", 32'(cmd_ready), 32'd1);
`ifdef ALU_DRV_CNT_EN
    check("midrst_op_count", 32'(op_count), 32'd0);
`endif
    rsp_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      check($sformatf("midrst_quiet_%0d", i), 32'(rsp_valid), 32'd0);
      step();
    end

    // Randomized traffic with random back-pressure.
    for (int i = 0; i < 400; i++) begin
      cmd_valid = ($urandom_range(0, 2) != 0);
      cmd_a     = $urandom;
      cmd_b     = $urandom;
      cmd_op    = 3'($urandom_range(0, 7));
      rsp_ready = ($urandom_range(0, 1) == 1);
      step();
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) step();
    check("rand_drain_pending", 32'(exp_q.size()), 32'd0);
    step();
    check("rand_busy_after", 32'(busy), 32'd0);
`ifdef ALU_DRV_CNT_EN
    check("rand_op_count", 32'(op_count), 32'(exp_cnt & 32'hFFFF));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_cmd_driver.md
# alu_cmd_driver

Command-side front end for the 32-bit combinational ALU. It accepts operand/opcode commands over a valid/ready handshake and buffers them in a small FIFO. It issues one command at a time on registered ALU input ports, captures the ALU result and flags, and returns them in order over a second valid/ready handshake. It sits between any command producer (sequencer, CPU stub, bench) and the ALU core.

## Interface
- WIDTH, 32, operand/result width
- DEPTH, 4, command FIFO entries (power of two, ≥2)

- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  FIFO can accept this cycle
- cmd_a, cmd_b  in  WIDTH  operands
- cmd_op  in  3  opcode: 000 sla, 001 sra, 010 add, 011 sub, 100 mul, 101 and, 110 or, 111 not
- alu_a, alu_b  out  WIDTH  registered operands to ALU
- alu_opcode  out  3  registered opcode to ALU
- alu_c  in  WIDTH  ALU result (combinational from alu_*)
- alu_d  in  3  ALU flags, carried transparently
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts response
- rsp_c  out  WIDTH  captured result
- rsp_d  out  3  captured flags
- rsp_op  out  3  opcode echo of the response
- busy  out  1  state≠IDLE or FIFO non-empty

## Operation
- Push: cmd_valid & cmd_ready writes {cmd_a, cmd_b, cmd_op} at wr_ptr. cmd_ready = (count≠DEPTH) & ~rst. No bypass: when full, a same-cycle pop does not raise cmd_ready.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. count is log2(DEPTH)+1 bits. Simultaneous push and pop leaves count unchanged.
- FSM states:
  - IDLE: if count≠0, pop the head, load alu_a/alu_b/alu_opcode and rsp_op, then go to EXEC.
  - EXEC: register alu_c→rsp_c and alu_d→rsp_d, set rsp_valid, then go to RESP.
  - RESP: hold rsp_* stable while ~rsp_ready. On rsp_valid & rsp_ready, clear rsp_valid. Then, if count≠0, pop and load the alu_* registers and go to EXEC; otherwise go to IDLE.
- alu_* hold their last value between operations. They change only on a pop.
- Responses leave in command order. Exactly one response per accepted command.
- Arithmetic is entirely inside the ALU. This block never alters data.

## Timing
- Reset, effective at the clock edge while rst=1:
  - FSM→IDLE; pointers and count→0.
  - alu_a, alu_b, alu_opcode, rsp_c, rsp_d, rsp_op→0.
  - rsp_valid=0, busy=0, cmd_ready=0 while rst is high and 1 from the first cycle after release.
- Latency: command accepted in cycle N into an idle, empty block → alu_* valid in N+2 → rsp_valid=1 in N+3.
- Throughput: with rsp_ready held at 1, one response every 2 cycles.
- Reset mid-operation: queued and in-flight commands are discarded. No response is emitted for them.
- Capacity: with rsp_ready=0, at most DEPTH+1 commands are outstanding (DEPTH queued plus one in RESP).

## Configuration
- ALU_DRV_CNT_EN defined: adds output op_count [15:0].
  - Reset value 0.
  - Increments on each rsp_valid & rsp_ready.
  - Wraps 0xFFFF→0x0000.
- ALU_DRV_CNT_EN undefined: port and counter logic are absent. All other behaviour is identical.

## Test plan
- Reset: hold rst for 2 cycles → all outputs 0 per the reset list; cmd_ready=1 and busy=0 in the first cycle after release.
- Single op: a=0xFFFFFFFF, op=111, rsp_ready=1 → rsp_valid=1 exactly 3 cycles after acceptance, rsp_c=0x00000000, rsp_op=111, rsp_valid=0 the following cycle.
- Ordering: add 5+7, then sub 3−10, back-to-back → rsp_c=0x0000000C (op 010), then rsp_c=0xFFFFFFF9 (op 011), 2 cycles apart.
- Back-pressure/full: rsp_ready=0, 6 back-to-back commands → exactly 5 accepted, cmd_ready=0 from the cycle after the 5th acceptance. Release rsp_ready → 5 responses in order, then cmd_ready=1.
- Reset mid-op: pulse rst while in RESP with 2 commands queued → after release rsp_valid=0, busy=0, and no response for 10 cycles.
- Counter (ALU_DRV_CNT_EN defined): 3 completed handshakes → op_count=3; reset → op_count=0.
